// File: rtl/bullet_slot_alloc_if.sv
// Fire-path bundle between the input decoder / bullet engines and the slot allocator.
// The master drives key and busy status; the slave returns launch pulses and status.
interface bullet_slot_alloc_if #(
    parameter int NUM_SLOTS = 5,
    parameter int CNT_W     = 8
);
    logic [NUM_SLOTS-1:0] slot_busy;
    logic                 fire_key;
    logic                 autofire_en;
    logic [NUM_SLOTS-1:0] fire;
    logic                 denied;
    logic                 ready;
    logic [CNT_W-1:0]     shot_count;

    modport master (
        output slot_busy, fire_key, autofire_en,
        input  fire, denied, ready, shot_count
    );

    modport slave (
        input  slot_busy, fire_key, autofire_en,
        output fire, denied, ready, shot_count
    );
endinterface

// File: rtl/bullet_slot_alloc.sv
// Fire-request arbiter: key edge or autofire -> one-hot launch pulse to a free bullet slot.
// Latency 1 cycle request->fire/denied; no backpressure, requests during cooldown are dropped.
module bullet_slot_alloc #(
    parameter int NUM_SLOTS = 5,
    parameter int CD_W      = 16,
    parameter int COOLDOWN  = 1000,
    parameter int RR_MODE   = 0,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    bullet_slot_alloc_if.slave      bus
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef logic [NUM_SLOTS-1:0] mask_t;

    logic             key_q, key_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    mask_t            reserved_q, reserved_d;
    logic [IDX_W-1:0] last_q, last_d;
    mask_t            fire_q, fire_d;
    logic             denied_q, denied_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    mask_t            free;
    mask_t            above;
    logic [IDX_W-1:0] sel_lo, sel_rr, sel;
    logic             req, grant, deny;

    // Slot selection: 'above' holds free slots past the last grant, which round-robin
    // prefers; when none remain the scan wraps, which is the lowest free slot.
    always_comb begin
        free   = ~(bus.slot_busy | reserved_q);
        above  = '0;
        sel_lo = '0;
        sel_rr = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            above[i] = free[i] && (IDX_W'(i) > last_q);
        end
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free[i])  sel_lo = IDX_W'(i);
            if (above[i]) sel_rr = IDX_W'(i);
        end
        sel   = ((RR_MODE != 0) && (|above)) ? sel_rr : sel_lo;
        req   = (cd_q == '0) && bus.fire_key && (!key_q || bus.autofire_en);
        grant = req && (|free);
        deny  = req && !(|free);
    end

    always_comb begin
        key_d      = bus.fire_key;
        fire_d     = '0;
        denied_d   = deny;
        cd_d       = cd_q;
        reserved_d = reserved_q & ~bus.slot_busy;
        last_d     = last_q;
        cnt_d      = cnt_q;
        if (cd_q != '0) begin
            cd_d = cd_q - CD_W'(1);
        end
        // Cooldown expiring releases any reservation whose engine never reported busy.
        if (cd_q == CD_W'(1)) begin
            reserved_d = '0;
        end
        if (grant) begin
            fire_d[sel]     = 1'b1;
            reserved_d[sel] = 1'b1;
            last_d          = sel;
            cd_d            = CD_W'(COOLDOWN);
            cnt_d           = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q      <= 1'b0;
            cd_q       <= '0;
            reserved_q <= '0;
            last_q     <= IDX_W'(NUM_SLOTS - 1);
            fire_q     <= '0;
            denied_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            key_q      <= key_d;
            cd_q       <= cd_d;
            reserved_q <= reserved_d;
            last_q     <= last_d;
            fire_q     <= fire_d;
            denied_q   <= denied_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.fire       = fire_q;
    assign bus.denied     = denied_q;
    assign bus.ready      = (cd_q == '0);
    assign bus.shot_count = cnt_q;
endmodule

// File: tb/tb_bullet_slot_alloc.sv
// Two allocators (lowest-index and round-robin, cooldown 4) share one stimulus stream;
// a negedge monitor pops per-instance expected launches/denials with their cycle stamps.
module tb_bullet_slot_alloc;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] slot_busy;
    logic       fire_key;
    logic       autofire_en;
    int         cyc = 0;
    int         n_total = 0;
    int         n_pass = 0;

    typedef struct {
        logic [4:0] fire;
        logic       denied;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    bullet_slot_alloc_if #(.NUM_SLOTS(5), .CNT_W(8)) if0 ();
    bullet_slot_alloc_if #(.NUM_SLOTS(5), .CNT_W(8)) if1 ();

    assign if0.slot_busy   = slot_busy;
    assign if0.fire_key    = fire_key;
    assign if0.autofire_en = autofire_en;
    assign if1.slot_busy   = slot_busy;
    assign if1.fire_key    = fire_key;
    assign if1.autofire_en = autofire_en;

    bullet_slot_alloc #(.NUM_SLOTS(5), .CD_W(16), .COOLDOWN(4), .RR_MODE(0), .CNT_W(8))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    bullet_slot_alloc #(.NUM_SLOTS(5), .CD_W(16), .COOLDOWN(4), .RR_MODE(1), .CNT_W(8))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cmp(input int d, input exp_t e, input logic [4:0] f, input logic dn,
                       input logic [7:0] cn);
        chk($sformatf("dut%0d fire@%0d", d, e.cyc), 32'(f), 32'(e.fire));
        chk($sformatf("dut%0d denied@%0d", d, e.cyc), 32'(dn), 32'(e.denied));
        chk($sformatf("dut%0d shot_count@%0d", d, e.cyc), 32'(cn), 32'(e.cnt));
        chk($sformatf("dut%0d cycle", d), 32'(cyc), 32'(e.cyc));
    endtask

    task automatic unexpected(input int d, input logic [4:0] f, input logic dn);
        n_total++;
        $display("FAIL dut%0d unexpected output at cycle %0d: fire=%b denied=%b expected none",
                 d, cyc, f, dn);
    endtask

    always @(negedge clk) begin
        if (if0.fire != 5'b0 || if0.denied) begin
            if (exp_q0.size() == 0) unexpected(0, if0.fire, if0.denied);
            else cmp(0, exp_q0.pop_front(), if0.fire, if0.denied, if0.shot_count);
        end
        if (if1.fire != 5'b0 || if1.denied) begin
            if (exp_q1.size() == 0) unexpected(1, if1.fire, if1.denied);
            else cmp(1, exp_q1.pop_front(), if1.fire, if1.denied, if1.shot_count);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] f0, input logic [4:0] f1, input logic den,
                        input logic [7:0] cnt, input int c);
        exp_t e;
        e.fire = f0; e.denied = den; e.cnt = cnt; e.cyc = c;
        exp_q0.push_back(e);
        e.fire = f1;
        exp_q1.push_back(e);
    endtask

    // One key edge, then idle until the cooldown has expired again.
    task automatic press(input logic [4:0] f0, input logic [4:0] f1, input logic [7:0] cnt);
        push(f0, f1, 1'b0, cnt, cyc + 1);
        fire_key = 1'b1;
        step(1);
        fire_key = 1'b0;
        step(5);
    endtask

    task automatic chk_both_ready(input string nm, input logic exp);
        chk({nm, " dut0 ready"}, 32'(if0.ready), 32'(exp));
        chk({nm, " dut1 ready"}, 32'(if1.ready), 32'(exp));
    endtask

    task automatic chk_both_cnt(input string nm, input logic [7:0] exp);
        chk({nm, " dut0 shot_count"}, 32'(if0.shot_count), 32'(exp));
        chk({nm, " dut1 shot_count"}, 32'(if1.shot_count), 32'(exp));
    endtask

    initial begin
        int c;
        logic [4:0] oh;
        rst = 1'b0; slot_busy = 5'b0; fire_key = 1'b0; autofire_en = 1'b0;
        step(2);
        chk("reset dut0 fire", 32'(if0.fire), 32'd0);
        chk("reset dut1 fire", 32'(if1.fire), 32'd0);
        chk("reset dut0 denied", 32'(if0.denied), 32'd0);
        chk("reset dut1 denied", 32'(if1.denied), 32'd0);
        chk_both_cnt("reset", 8'd0);
        chk_both_ready("reset", 1'b1);
        rst = 1'b1;
        step(1);

        // First edge: slot 0 in both modes, then ready low for exactly 4 cycles.
        push(5'b00001, 5'b00001, 1'b0, 8'd1, cyc + 1);
        fire_key = 1'b1;
        step(1);
        chk_both_cnt("first grant", 8'd1);
        for (int k = 0; k < 4; k++) begin
            chk_both_ready($sformatf("cooldown %0d", k), 1'b0);
            step(1);
        end
        chk_both_ready("cooldown expired", 1'b1);
        fire_key = 1'b0;
        step(1);

        // Round-robin walk and wrap; lowest-index stays on slot 0.
        press(5'b00001, 5'b00010, 8'd2);
        press(5'b00001, 5'b00100, 8'd3);
        press(5'b00001, 5'b01000, 8'd4);
        press(5'b00001, 5'b10000, 8'd5);
        press(5'b00001, 5'b00001, 8'd6);

        // Partial busy masks.
        slot_busy = 5'b00010; press(5'b00001, 5'b00100, 8'd7);
        slot_busy = 5'b00101; press(5'b00010, 5'b01000, 8'd8);
        slot_busy = 5'b11000; press(5'b00001, 5'b00001, 8'd9);

        // All busy: deny, no cooldown, count unchanged.
        slot_busy = 5'b11111;
        push(5'b0, 5'b0, 1'b1, 8'd9, cyc + 1);
        fire_key = 1'b1;
        step(1);
        chk_both_ready("after deny", 1'b1);
        chk_both_cnt("after deny", 8'd9);
        fire_key = 1'b0;
        step(2);

        // Autofire retries a denied request every cycle until a slot frees.
        autofire_en = 1'b1; fire_key = 1'b1;
        push(5'b0, 5'b0, 1'b1, 8'd9, cyc + 1); step(1);
        push(5'b0, 5'b0, 1'b1, 8'd9, cyc + 1); step(1);
        push(5'b0, 5'b0, 1'b1, 8'd9, cyc + 1); step(1);
        slot_busy = 5'b0;
        push(5'b00001, 5'b00010, 1'b0, 8'd10, cyc + 1); step(1);
        fire_key = 1'b0;
        step(5);

        // Autofire with a held key: a pulse every 5 cycles, none after release.
        fire_key = 1'b1;
        c = cyc;
        push(5'b00001, 5'b00100, 1'b0, 8'd11, c + 1);
        push(5'b00001, 5'b01000, 1'b0, 8'd12, c + 6);
        push(5'b00001, 5'b10000, 1'b0, 8'd13, c + 11);
        step(11);
        fire_key = 1'b0;
        step(10);
        autofire_en = 1'b0;

        // Edge one cycle before expiry is dropped; slot 0 regranted at expiry.
        slot_busy = 5'b11110;
        push(5'b00001, 5'b00001, 1'b0, 8'd14, cyc + 1);
        fire_key = 1'b1; step(1);
        fire_key = 1'b0; step(3);
        chk_both_ready("expiry-1", 1'b0);
        fire_key = 1'b1; step(1);
        chk_both_ready("expiry", 1'b1);
        fire_key = 1'b0; step(1);
        push(5'b00001, 5'b00001, 1'b0, 8'd15, cyc + 1);
        fire_key = 1'b1; step(1);
        fire_key = 1'b0; step(5);
        slot_busy = 5'b0;

        // Asynchronous reset in the middle of cooldown.
        push(5'b00001, 5'b00010, 1'b0, 8'd16, cyc + 1);
        fire_key = 1'b1; step(1);
        fire_key = 1'b0; step(2);
        #2 rst = 1'b0;
        #1;
        chk_both_cnt("mid-cooldown reset", 8'd0);
        chk_both_ready("mid-cooldown reset", 1'b1);

        // Key held through reset release fires once.
        fire_key = 1'b1;
        step(1);
        #2 rst = 1'b1;
        push(5'b00001, 5'b00001, 1'b0, 8'd1, cyc + 1);
        step(11);

        // Asynchronous reset during a fire pulse.
        fire_key = 1'b0; step(1);
        fire_key = 1'b1; step(1);
        chk("pulse dut0 fire", 32'(if0.fire), 32'(5'b00001));
        chk("pulse dut1 fire", 32'(if1.fire), 32'(5'b00010));
        #1 rst = 1'b0;
        #1;
        chk("pulse reset dut0 fire", 32'(if0.fire), 32'd0);
        chk("pulse reset dut1 fire", 32'(if1.fire), 32'd0);
        chk_both_cnt("pulse reset", 8'd0);
        step(1);
        fire_key = 1'b0; rst = 1'b1;
        step(1);

        // 256 autofire grants: shot_count wraps 255 -> 0.
        autofire_en = 1'b1; fire_key = 1'b1;
        c = cyc;
        for (int k = 1; k <= 256; k++) begin
            oh = 5'b00001 << ((k - 1) % 5);
            push(5'b00001, oh, 1'b0, 8'(k), c + 1 + 5 * (k - 1));
        end
        step(1 + 5 * 255);
        fire_key = 1'b0; autofire_en = 1'b0;
        step(10);
        chk_both_cnt("wrap", 8'd0);

        chk("dut0 pending expectations", 32'(exp_q0.size()), 32'd0);
        chk("dut1 pending expectations", 32'(exp_q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
